// File: rtl/mxint8_add_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mxint8_add_sched_pkg
// Brief    : Shared MXINT8 block and tagged-response types for the add scheduler.
// Revision : 1.0
// ============================================================================
package mxint8_add_sched_pkg;

  localparam int SCALE_WIDTH          = 8;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int BLOCK_SIZE           = 4;
  localparam int ID_MAX_WIDTH         = 3;

  typedef logic [SCALE_WIDTH-1:0] mx_scale_t;
  typedef logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] mx_elems_t;

  typedef struct packed {
    mx_scale_t scale;
    mx_elems_t elem;
  } mx_block_t;

  // The id field is sized for the largest requester count; tops truncate it.
  typedef struct packed {
    logic [ID_MAX_WIDTH-1:0] id;
    mx_block_t               blk;
  } mx_resp_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/mxint8_add_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mxint8_add_sched_if
// Brief    : Requester, adder and response bundle of the MXINT8 add scheduler.
// Revision : 1.0
// ============================================================================
interface mxint8_add_sched_if #(
  parameter int NUM_REQ = 2
) ();
  import mxint8_add_sched_pkg::*;

  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  mx_scale_t [NUM_REQ-1:0] req_scale_a;
  mx_scale_t [NUM_REQ-1:0] req_scale_b;
  mx_elems_t [NUM_REQ-1:0] req_elem_a;
  mx_elems_t [NUM_REQ-1:0] req_elem_b;

  mx_scale_t add_scale_a;
  mx_scale_t add_scale_b;
  mx_elems_t add_elem_a;
  mx_elems_t add_elem_b;
  mx_scale_t add_scale_y;
  mx_elems_t add_elem_y;

  logic                resp_valid;
  logic                resp_ready;
  logic [ID_WIDTH-1:0] resp_id;
  mx_scale_t           resp_scale;
  mx_elems_t           resp_elem;

  logic flush;
  logic flush_done;

  modport slave (
    input  req_valid, req_scale_a, req_scale_b, req_elem_a, req_elem_b,
    input  add_scale_y, add_elem_y, resp_ready, flush,
    output req_ready, add_scale_a, add_scale_b, add_elem_a, add_elem_b,
    output resp_valid, resp_id, resp_scale, resp_elem, flush_done
  );

  modport master (
    output req_valid, req_scale_a, req_scale_b, req_elem_a, req_elem_b,
    output add_scale_y, add_elem_y, resp_ready, flush,
    input  req_ready, add_scale_a, add_scale_b, add_elem_a, add_elem_b,
    input  resp_valid, resp_id, resp_scale, resp_elem, flush_done
  );

endinterface
`default_nettype wire

// File: rtl/mxint8_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mxint8_resp_fifo
// Brief    : Synchronous response FIFO with occupancy count; head always visible.
// Revision : 1.0
// ============================================================================
module mxint8_resp_fifo
  import mxint8_add_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push_i,
  input  wire mx_resp_t                 push_data_i,
  input  wire logic                     pop_i,
  output mx_resp_t                      head_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  mx_resp_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 do_push;
  logic                 do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mxint8_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : mxint8_add_sched
// Brief    : Round-robin scheduler sharing one MXINT8 block adder among requesters.
//            Define MXINT8_ADD_SCHED_PERF_EN to add issue/stall counters.
// Revision : 1.0
// ============================================================================
module mxint8_add_sched
  import mxint8_add_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADD_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mxint8_add_sched_if.slave  bus
`ifdef MXINT8_ADD_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_issue_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e                         state_q;
  sched_state_e                         state_d;
  logic [ID_WIDTH-1:0]                  ptr_q;
  logic [ADD_LATENCY-1:0]               tag_vld_q;
  logic [ADD_LATENCY-1:0][ID_WIDTH-1:0] tag_id_q;
  mx_scale_t                            add_scale_a_q;
  mx_scale_t                            add_scale_b_q;
  mx_elems_t                            add_elem_a_q;
  mx_elems_t                            add_elem_b_q;

  logic [ID_WIDTH-1:0]     grant_idx;
  logic                    grant_hit;
  logic [NUM_REQ-1:0]      ready;
  logic                    issue_en;
  logic                    transfer;
  logic                    flush_done;
  logic [31:0]             inflight;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                    fifo_empty;
  mx_resp_t                push_data;
  mx_resp_t                resp_head;

  // Search starts just after the last grant and wraps.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    grant_hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_hit && bus.req_valid[idx]) begin
        grant_hit = 1'b1;
        grant_idx = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ADD_LATENCY; i++) begin
      inflight = inflight + 32'(tag_vld_q[i]);
    end
  end

  // Credit counts in-flight issues so every result has a guaranteed FIFO slot.
  assign issue_en = (state_q == ST_RUN) && !bus.flush
                    && ((32'(fifo_count) + inflight) < 32'(FIFO_DEPTH));
  assign transfer = issue_en && grant_hit;

  always_comb begin
    ready = '0;
    if (transfer) begin
      ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && fifo_empty) begin
          state_d    = ST_RUN;
          flush_done = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      ptr_q         <= ID_WIDTH'(NUM_REQ - 1);
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      add_scale_a_q <= '0;
      add_scale_b_q <= '0;
      add_elem_a_q  <= '0;
      add_elem_b_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_vld_q[0] <= transfer;
      tag_id_q[0]  <= grant_idx;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      if (transfer) begin
        ptr_q         <= grant_idx;
        add_scale_a_q <= bus.req_scale_a[grant_idx];
        add_scale_b_q <= bus.req_scale_b[grant_idx];
        add_elem_a_q  <= bus.req_elem_a[grant_idx];
        add_elem_b_q  <= bus.req_elem_b[grant_idx];
      end
    end
  end

  always_comb begin
    push_data           = '0;
    push_data.id        = ID_MAX_WIDTH'(tag_id_q[ADD_LATENCY-1]);
    push_data.blk.scale = bus.add_scale_y;
    push_data.blk.elem  = bus.add_elem_y;
  end

  mxint8_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (tag_vld_q[ADD_LATENCY-1]),
    .push_data_i (push_data),
    .pop_i       (bus.resp_valid && bus.resp_ready),
    .head_o      (resp_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.req_ready   = ready;
  assign bus.add_scale_a = add_scale_a_q;
  assign bus.add_scale_b = add_scale_b_q;
  assign bus.add_elem_a  = add_elem_a_q;
  assign bus.add_elem_b  = add_elem_b_q;
  assign bus.resp_valid  = !fifo_empty;
  assign bus.resp_id     = ID_WIDTH'(resp_head.id);
  assign bus.resp_scale  = resp_head.blk.scale;
  assign bus.resp_elem   = resp_head.blk.elem;
  assign bus.flush_done  = flush_done;

`ifdef MXINT8_ADD_SCHED_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (transfer) begin
        perf_issue_q <= perf_issue_q + 32'd1;
      end
      if ((|bus.req_valid) && !transfer) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mxint8_add_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxint8_add_sched
// Brief    : Scoreboard bench for mxint8_add_sched with a 2-cycle MXINT8 add model.
// Revision : 1.0
// ============================================================================
module tb_mxint8_add_sched;
  import mxint8_add_sched_pkg::*;

  typedef struct {
    int        id;
    mx_block_t blk;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  string phase;
  exp_t sbq[$];
  mx_block_t opa[2];
  mx_block_t opb[2];
  mx_block_t adder_q;

  mxint8_add_sched_if #(.NUM_REQ(2)) bus ();

`ifdef MXINT8_ADD_SCHED_PERF_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_stall;
`endif

  mxint8_add_sched #(
    .NUM_REQ     (2),
    .ADD_LATENCY (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MXINT8_ADD_SCHED_PERF_EN
    ,
    .perf_issue_cnt (perf_issue),
    .perf_stall_cnt (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block add: align to the larger scale, add elementwise, saturate to int8.
  function automatic mx_block_t mx_add(input mx_block_t a, input mx_block_t b);
    mx_block_t         y;
    logic signed [9:0] sum;
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    logic [7:0]        sha;
    logic [7:0]        shb;
    y.scale = (a.scale > b.scale) ? a.scale : b.scale;
    sha = y.scale - a.scale;
    shb = y.scale - b.scale;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      ea  = $signed(a.elem[j]) >>> sha;
      eb  = $signed(b.elem[j]) >>> shb;
      sum = {{2{ea[7]}}, ea} + {{2{eb[7]}}, eb};
      if (sum > 10'sd127)       y.elem[j] = 8'h7f;
      else if (sum < -10'sd128) y.elem[j] = 8'h80;
      else                      y.elem[j] = sum[7:0];
    end
    return y;
  endfunction

  // Adder with one register stage after the scheduler's operand registers.
  always @(posedge clk) begin
    adder_q <= mx_add('{scale: bus.add_scale_a, elem: bus.add_elem_a},
                      '{scale: bus.add_scale_b, elem: bus.add_elem_b});
  end
  assign bus.add_scale_y = adder_q.scale;
  assign bus.add_elem_y  = adder_q.elem;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s actual=%0h expected=%0h", phase, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL %s/resp_unexpected actual id=%0d scale=%0h elem=%0h expected none",
                 phase, bus.resp_id, bus.resp_scale, bus.resp_elem);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (32'(bus.resp_id) != e.id || bus.resp_scale !== e.blk.scale
            || bus.resp_elem !== e.blk.elem) begin
          n_fail++;
          $display("FAIL %s/resp actual id=%0d scale=%0h elem=%0h expected id=%0d scale=%0h elem=%0h",
                   phase, bus.resp_id, bus.resp_scale, bus.resp_elem,
                   e.id, e.blk.scale, e.blk.elem);
        end
      end
    end
  end

  task automatic set_pat(input int s);
    for (int i = 0; i < 2; i++) begin
      opa[i].scale = 8'(10 + i);
      opb[i].scale = 8'(10 + i + (s % 3));
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        opa[i].elem[j] = 8'(s * 16 + i * 4 + j);
        opb[i].elem[j] = 8'(s * 3 - j * 37 - i);
      end
    end
  endtask

  // One clock of stimulus; inputs change just after posedge, checks at negedge.
  task automatic drive(input logic [1:0] v, input logic fl, input logic rr,
                       input logic [1:0] exp_rdy, input logic exp_fd, input int exp_rv);
    int   id;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      bus.req_scale_a[i] = opa[i].scale;
      bus.req_scale_b[i] = opb[i].scale;
      bus.req_elem_a[i]  = opa[i].elem;
      bus.req_elem_b[i]  = opb[i].elem;
    end
    bus.req_valid  = v;
    bus.flush      = fl;
    bus.resp_ready = rr;
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("flush_done", 64'(bus.flush_done), 64'(exp_fd));
    if (exp_rv >= 0) chk("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
    id = (exp_rdy == 2'b10) ? 1 : 0;
    if (exp_rdy != 2'b00) begin
      e.id  = id;
      e.blk = mx_add(opa[id], opb[id]);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (exp_rdy != 2'b00) begin
      chk("add_scale_a", 64'(bus.add_scale_a), 64'(opa[id].scale));
      chk("add_scale_b", 64'(bus.add_scale_b), 64'(opb[id].scale));
      chk("add_elem_a", 64'(bus.add_elem_a), 64'(opa[id].elem));
      chk("add_elem_b", 64'(bus.add_elem_b), 64'(opb[id].elem));
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < max_cycles) begin
      drive(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, -1);
      c++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bp_seq [6];
    logic [1:0] rel_seq [5];
    n_chk = 0;
    n_fail = 0;
    phase = "reset";
    rst_n = 1'b0;
    set_pat(0);
    bus.req_valid = '0;
    bus.flush = 1'b0;
    bus.resp_ready = 1'b1;
    bus.req_scale_a = '0; bus.req_scale_b = '0;
    bus.req_elem_a = '0;  bus.req_elem_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'd0);
    chk("resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("flush_done", 64'(bus.flush_done), 64'd0);
    chk("resp_id", 64'(bus.resp_id), 64'd0);
    chk("resp_scale", 64'(bus.resp_scale), 64'd0);
    chk("resp_elem", 64'(bus.resp_elem), 64'd0);
    chk("add_scale_a", 64'(bus.add_scale_a), 64'd0);
    chk("add_elem_b", 64'(bus.add_elem_b), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    phase = "single";
    set_pat(1);
    drive(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 0);
    set_pat(2);
    drive(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 0);
    drive(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 0);
    drive(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1);
    wait_drain(10);

    // Last grant was 0, so requester 1 leads the alternation.
    phase = "contention";
    for (int k = 0; k < 6; k++) begin
      set_pat(3 + k);
      drive(2'b11, 1'b0, 1'b1, (k % 2 == 0) ? 2'b10 : 2'b01, 1'b0, -1);
    end
    wait_drain(10);

    phase = "backpressure";
    bp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    for (int k = 0; k < 6; k++) begin
      set_pat(10 + k);
      drive(2'b11, 1'b0, 1'b0, bp_seq[k], 1'b0, -1);
    end
    phase = "release";
    rel_seq = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int k = 0; k < 5; k++) begin
      set_pat(20 + k);
      drive(2'b11, 1'b0, 1'b1, rel_seq[k], 1'b0, 1);
    end
    wait_drain(12);

    phase = "flush";
    set_pat(30);
    drive(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 0);
    set_pat(31);
    drive(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, 0);
    drive(2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 0);
    drive(2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1);
    drive(2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1);
    drive(2'b11, 1'b0, 1'b1, 2'b00, 1'b1, 0);
    set_pat(32);
    drive(2'b11, 1'b0, 1'b1, 2'b10, 1'b0, 0);
    wait_drain(10);

    phase = "reset_mid";
    set_pat(40);
    drive(2'b11, 1'b0, 1'b0, 2'b01, 1'b0, -1);
    drive(2'b11, 1'b0, 1'b0, 2'b10, 1'b0, -1);
    drive(2'b11, 1'b0, 1'b0, 2'b01, 1'b0, -1);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, -1);
    drive(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) drive(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      set_pat(50 + k);
      drive(2'b11, 1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, -1);
    end
    wait_drain(10);

    phase = "special";
    opa[0] = '0;
    opb[0] = '0;
    drive(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, -1);
    opa[1].scale = 8'd5;
    opb[1].scale = 8'd5;
    opa[1].elem  = {BLOCK_SIZE{8'h80}};
    opb[1].elem  = {BLOCK_SIZE{8'h80}};
    drive(2'b10, 1'b0, 1'b1, 2'b10, 1'b0, -1);
    opa[0].elem = {BLOCK_SIZE{8'h80}};
    drive(2'b01, 1'b0, 1'b1, 2'b01, 1'b0, -1);
    wait_drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
